// File: rtl/lane_tx_vc_unit.sv
// lane_tx_vc_unit: per-VC packet buffering, header phit insertion,
// round-robin packet arbitration and per-VC credit metering for one SL3 lane.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no packet in flight; arbitrate among eligible VCs
// ST_HEADER  | header phit of cur_vc packet offered; FIFO not popped
// ST_PAYLOAD | payload words of cur_vc offered; each accept pops the FIFO
module lane_tx_vc_unit #(
  parameter int NUM_VC       = 2,
  parameter int PHIT_WIDTH   = 128,
  parameter int HEADER_WIDTH = 48,
  parameter int DEPTH_BITS   = 9,
  parameter int CREDIT_WIDTH = 12,
  parameter int INIT_CREDITS = 64,
  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [VCW-1:0]                 in_vc,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic [HEADER_WIDTH-1:0]        in_header,
  input  logic [PHIT_WIDTH-1:0]          in_data,
  output logic [NUM_VC-1:0]              in_ready,
  output logic                           tx_valid,
  output logic                           tx_last,
  output logic [PHIT_WIDTH-1:0]          tx_data,
  output logic [VCW-1:0]                 tx_vc,
  input  logic                           tx_full,
  input  logic                           credit_valid,
  input  logic [VCW-1:0]                 credit_vc,
  input  logic [CREDIT_WIDTH-1:0]        credit_data,
  output logic                           credit_grant,
  output logic [NUM_VC*CREDIT_WIDTH-1:0] credits,
  output logic [47:0]                    stats
);

  localparam int DEPTH   = 1 << DEPTH_BITS;
  localparam int ENTRY_W = 2 + HEADER_WIDTH + PHIT_WIDTH;
  localparam logic [DEPTH_BITS:0]     CNT_FULL    = (DEPTH_BITS+1)'(DEPTH);
  localparam logic [DEPTH_BITS:0]     CNT_READY   = (DEPTH_BITS+1)'(DEPTH - 8);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_INIT = CREDIT_WIDTH'(INIT_CREDITS);

  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD} state_t;

  state_t                  state_q, state_d;
  logic [VCW-1:0]          cur_vc_q, cur_vc_d;
  logic [VCW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0] credit_q [NUM_VC];
  logic [CREDIT_WIDTH-1:0] credit_d [NUM_VC];
  logic [CREDIT_WIDTH:0]   credit_sum [NUM_VC];
  logic [DEPTH_BITS:0]     cnt_q [NUM_VC];
  logic [DEPTH_BITS:0]     cnt_d [NUM_VC];
  logic [DEPTH_BITS-1:0]   wr_ptr_q [NUM_VC];
  logic [DEPTH_BITS-1:0]   wr_ptr_d [NUM_VC];
  logic [DEPTH_BITS-1:0]   rd_ptr_q [NUM_VC];
  logic [DEPTH_BITS-1:0]   rd_ptr_d [NUM_VC];
  logic [15:0]             phits_q, phits_d;
  logic [15:0]             pkts_q, pkts_d;
  logic [15:0]             bp_q, bp_d;

  // Entry layout: {first, last, header, data}
  logic [ENTRY_W-1:0]      fifo_mem [NUM_VC][DEPTH];

  logic [DEPTH_BITS-1:0]   cur_rd;
  logic [HEADER_WIDTH-1:0] cur_header;
  logic [PHIT_WIDTH-1:0]   cur_data;
  logic                    cur_last;
  logic                    cur_head_valid;
  logic                    cur_credit_ok;
  logic [NUM_VC-1:0]       eligible;
  logic                    win_found;
  logic [VCW-1:0]          win_vc;
  logic [VCW-1:0]          cand;
  logic                    accept;
  logic                    wr_en;
  logic                    pop_en;

  assign accept       = tx_valid & ~tx_full;
  assign tx_vc        = cur_vc_q;
  assign credit_grant = credit_valid;
  assign stats        = {bp_q, pkts_q, phits_q};

  // Head-of-FIFO views: eligibility of every VC and the fields of cur_vc's head
  always_comb begin
    eligible = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      eligible[v] = (cnt_q[v] != '0) && fifo_mem[v][rd_ptr_q[v]][ENTRY_W-1] &&
                    (credit_q[v] != '0);
    end
    cur_rd         = rd_ptr_q[cur_vc_q];
    cur_data       = fifo_mem[cur_vc_q][cur_rd][PHIT_WIDTH-1:0];
    cur_header     = fifo_mem[cur_vc_q][cur_rd][PHIT_WIDTH +: HEADER_WIDTH];
    cur_last       = fifo_mem[cur_vc_q][cur_rd][ENTRY_W-2];
    cur_head_valid = (cnt_q[cur_vc_q] != '0);
    cur_credit_ok  = (credit_q[cur_vc_q] != '0);
  end

  // Lane outputs; a stalled packet keeps cur_vc and never lets another VC in
  always_comb begin
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    case (state_q)
      ST_HEADER: begin
        tx_valid = cur_credit_ok;
        tx_data  = {{(PHIT_WIDTH-HEADER_WIDTH){1'b0}}, cur_header};
      end
      ST_PAYLOAD: begin
        tx_valid = cur_credit_ok & cur_head_valid;
        if (cur_head_valid) begin
          tx_data = cur_data;
          tx_last = cur_last;
        end
      end
      default: ;
    endcase
  end

  // Next state and round-robin arbitration starting after the last winner
  always_comb begin
    state_d   = state_q;
    cur_vc_d  = cur_vc_q;
    rr_ptr_d  = rr_ptr_q;
    win_found = 1'b0;
    win_vc    = '0;
    cand      = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      cand = VCW'((int'(rr_ptr_q) + i) % NUM_VC);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_vc    = cand;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_HEADER;
          cur_vc_d = win_vc;
          rr_ptr_d = VCW'((int'(win_vc) + 1) % NUM_VC);
        end
      end
      ST_HEADER:  if (accept) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (accept && tx_last) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FIFO pointers, saturating credit counters, readiness and statistics
  always_comb begin
    wr_en    = in_valid && (int'(in_vc) < NUM_VC) && (cnt_q[in_vc] != CNT_FULL);
    pop_en   = accept && (state_q == ST_PAYLOAD);
    in_ready = '0;
    credits  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      cnt_d[v]    = cnt_q[v];
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      if (wr_en && (int'(in_vc) == v)) begin
        wr_ptr_d[v] = wr_ptr_q[v] + 1'b1;
        cnt_d[v]    = cnt_d[v] + 1'b1;
      end
      if (pop_en && (int'(cur_vc_q) == v)) begin
        rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
        cnt_d[v]    = cnt_d[v] - 1'b1;
      end
      // accept implies a nonzero counter, so the decrement never underflows
      credit_sum[v] = {1'b0, credit_q[v]};
      if (credit_valid && (int'(credit_vc) == v)) begin
        credit_sum[v] = credit_sum[v] + {1'b0, credit_data};
      end
      if (accept && (int'(cur_vc_q) == v)) begin
        credit_sum[v] = credit_sum[v] - 1'b1;
      end
      credit_d[v] = credit_sum[v][CREDIT_WIDTH] ? '1 : credit_sum[v][CREDIT_WIDTH-1:0];
      in_ready[v] = (cnt_q[v] < CNT_READY);
      credits[v*CREDIT_WIDTH +: CREDIT_WIDTH] = credit_q[v];
    end
    phits_d = phits_q + (accept ? 16'd1 : 16'd0);
    pkts_d  = pkts_q + ((accept && tx_last) ? 16'd1 : 16'd0);
    bp_d    = (tx_full && (bp_q != 16'hFFFF)) ? bp_q + 16'd1 : bp_q;
  end

  // State, pointer, credit and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_vc_q <= '0;
      rr_ptr_q <= '0;
      phits_q  <= '0;
      pkts_q   <= '0;
      bp_q     <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        credit_q[v] <= CREDIT_INIT;
        cnt_q[v]    <= '0;
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cur_vc_q <= cur_vc_d;
      rr_ptr_q <= rr_ptr_d;
      phits_q  <= phits_d;
      pkts_q   <= pkts_d;
      bp_q     <= bp_d;
      for (int v = 0; v < NUM_VC; v++) begin
        credit_q[v] <= credit_d[v];
        cnt_q[v]    <= cnt_d[v];
        wr_ptr_q[v] <= wr_ptr_d[v];
        rd_ptr_q[v] <= rd_ptr_d[v];
      end
    end
  end

  // Packet word storage; emptiness is tracked by the counters, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[in_vc][wr_ptr_q[in_vc]] <= {in_first, in_last, in_header, in_data};
    end
  end

endmodule
